// File: rtl/ifm_skew_feeder_pkg.sv
// Shared types for the left-edge activation feeder: FSM states, stage control
// bits and the drain counter sizing helper.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feed_state_t;

  // Control half of the stage vector; the activation data rides alongside it.
  typedef struct packed {
    logic en;
    logic clr;
  } stage_ctl_t;

  localparam int DRAIN_CNT_W_DEFAULT = 3;

  function automatic int drain_cnt_w(input int rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/ifm_skew_feeder_skew_dly.sv
// Reset-cleared shift register of DELAY stages; one instance per array row
// carries {en, clr, data} together so they stay aligned.
module skew_dly #(
  parameter int WIDTH = 10,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DELAY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DELAY-1];

endmodule

// File: rtl/ifm_skew_feeder.sv
// Diagonal-skew activation feeder for the systolic array's border PEs.
// Optional beat/bubble counters enabled by IFM_SKEW_FEEDER_PERF_EN.
module ifm_skew_feeder
  import feeder_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int IWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ROWS*IWIDTH-1:0]   s_data,
  input  logic                     s_last,
  output logic [ROWS-1:0]          en_i,
  output logic [ROWS-1:0]          clr_i,
  output logic [ROWS*IWIDTH-1:0]   ifm,
  output logic                     busy,
`ifdef IFM_SKEW_FEEDER_PERF_EN
  output logic [CWIDTH-1:0]        perf_beats,
  output logic [CWIDTH-1:0]        perf_bubbles,
`endif
  output logic                     tile_done
);

  localparam int DCW = drain_cnt_w(ROWS);
  localparam int VW  = IWIDTH + 2;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROWS - 1);

  feed_state_t            state, state_nxt;
  logic [DCW-1:0]         drain_cnt;
  logic                   first_beat;
  logic                   accept;
  stage_ctl_t             ctl_p0;
  logic [ROWS*IWIDTH-1:0] data_p0;
  logic [VW-1:0]          row_vec [ROWS];

  assign s_ready   = (state != DRAIN);
  assign accept    = s_valid && s_ready;
  assign busy      = (state != IDLE);
  // DRAIN spans ROWS cycles so the last beat lands on row ROWS-1 with tile_done.
  assign tile_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = s_last ? DRAIN : STREAM;
      STREAM:  if (accept && s_last) state_nxt = DRAIN;
      DRAIN:   if (tile_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      first_beat <= 1'b1;
    end else begin
      state     <= state_nxt;
      drain_cnt <= ((state == DRAIN) && !tile_done) ? drain_cnt + DCW'(1) : '0;
      if (accept)         first_beat <= 1'b0;
      else if (tile_done) first_beat <= 1'b1;
    end
  end

  // ---- stage 0: per-cycle vector, zero data on bubbles ----
  always_comb begin
    ctl_p0.en  = accept;
    ctl_p0.clr = accept && first_beat;
    data_p0    = accept ? s_data : '0;
  end

  // ---- stages 1..ROWS: row r delayed by r+1 ----
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_dly #(
      .WIDTH (VW),
      .DELAY (r + 1)
    ) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({ctl_p0.en, ctl_p0.clr, data_p0[r*IWIDTH +: IWIDTH]}),
      .dout  (row_vec[r])
    );
    assign en_i[r]                  = row_vec[r][VW-1];
    assign clr_i[r]                 = row_vec[r][VW-2];
    assign ifm[r*IWIDTH +: IWIDTH]  = row_vec[r][IWIDTH-1:0];
  end

`ifdef IFM_SKEW_FEEDER_PERF_EN
  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v,
                                                input logic inc);
    return (inc && (v != '1)) ? v + CWIDTH'(1) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats   <= '0;
      perf_bubbles <= '0;
    end else begin
      perf_beats   <= sat_inc(perf_beats, accept);
      perf_bubbles <= sat_inc(perf_bubbles, (state == STREAM) && !s_valid);
    end
  end
`else
  // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// Randomised and directed bench for ifm_skew_feeder against a cycle-history
// reference model (tile timing derived from the last accepted beat).
module tb_ifm_skew_feeder;

  localparam int ROWS = 4;
  localparam int IW   = 8;
`ifdef IFM_SKEW_FEEDER_PERF_EN
  localparam int CW   = 4;
`else
  localparam int CW   = 16;
`endif
  localparam int MAXC = 2048;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [ROWS*IW-1:0]   s_data = '0;
  logic                 s_last = 1'b0;
  logic [ROWS-1:0]      en_i;
  logic [ROWS-1:0]      clr_i;
  logic [ROWS*IW-1:0]   ifm;
  logic                 busy;
  logic                 tile_done;
`ifdef IFM_SKEW_FEEDER_PERF_EN
  logic [CW-1:0]        perf_beats;
  logic [CW-1:0]        perf_bubbles;
`endif

  ifm_skew_feeder #(.ROWS(ROWS), .IWIDTH(IW), .CWIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .ifm          (ifm),
    .busy         (busy),
`ifdef IFM_SKEW_FEEDER_PERF_EN
    .perf_beats   (perf_beats),
    .perf_bubbles (perf_bubbles),
`endif
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int base  = 1;

  // reference model state
  logic               hist_en   [MAXC];
  logic               hist_clr  [MAXC];
  logic [ROWS*IW-1:0] hist_data [MAXC];
  logic               m_first;
  logic               m_in_tile;
  int                 m_drain_end;
  int                 m_beats;
  int                 m_bubbles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_first     = 1'b1;
    m_in_tile   = 1'b0;
    m_drain_end = -1;
    m_beats     = 0;
    m_bubbles   = 0;
    base        = n + 1;
  endtask

  task automatic run_cycle(input logic v, input logic [ROWS*IW-1:0] d, input logic l);
    logic               e_ready, e_done, acc;
    logic [ROWS-1:0]    e_en, e_clr;
    logic [ROWS*IW-1:0] e_ifm;
    int                 idx;
    @(posedge clk);
    #1;
    n++;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    e_ready = !(m_drain_end >= 0 && n > m_drain_end - ROWS && n <= m_drain_end);
    e_done  = (n == m_drain_end);
    e_en = '0; e_clr = '0; e_ifm = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = n - r - 1;
      if (idx >= base) begin
        e_en[r]            = hist_en[idx];
        e_clr[r]           = hist_clr[idx];
        e_ifm[r*IW +: IW]  = hist_data[idx][r*IW +: IW];
      end
    end
    check("s_ready",   64'(s_ready),   64'(e_ready));
    check("busy",      64'(busy),      64'(m_in_tile));
    check("tile_done", 64'(tile_done), 64'(e_done));
    check("en_i",      64'(en_i),      64'(e_en));
    check("clr_i",     64'(clr_i),     64'(e_clr));
    check("ifm",       64'(ifm),       64'(e_ifm));
`ifdef IFM_SKEW_FEEDER_PERF_EN
    check("perf_beats",   64'(perf_beats),   64'((m_beats   > 2**CW-1) ? 2**CW-1 : m_beats));
    check("perf_bubbles", 64'(perf_bubbles), 64'((m_bubbles > 2**CW-1) ? 2**CW-1 : m_bubbles));
`endif
    acc          = v && e_ready;
    hist_en[n]   = acc;
    hist_clr[n]  = acc && m_first;
    hist_data[n] = acc ? d : '0;
    if (acc) m_beats++;
    if (m_in_tile && e_ready && !v) m_bubbles++;
    if (acc) begin
      m_first   = 1'b0;
      m_in_tile = 1'b1;
      if (l) m_drain_end = n + ROWS;
    end
    if (e_done) begin
      m_first     = 1'b1;
      m_in_tile   = 1'b0;
      m_drain_end = -1;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) run_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic tile_s1();
    run_cycle(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
    run_cycle(1'b1, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b0);
    run_cycle(1'b1, {8'd12, 8'd11, 8'd10, 8'd9}, 1'b1);
    idle(6);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_en",    64'(en_i),      64'(0));
    check("rst_clr",   64'(clr_i),     64'(0));
    check("rst_ifm",   64'(ifm),       64'(0));
    check("rst_ready", 64'(s_ready),   64'(1));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_done",  64'(tile_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #3;
    check("init_ready", 64'(s_ready),   64'(1));
    check("init_en",    64'(en_i),      64'(0));
    check("init_clr",   64'(clr_i),     64'(0));
    check("init_ifm",   64'(ifm),       64'(0));
    check("init_busy",  64'(busy),      64'(0));
    check("init_done",  64'(tile_done), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // three-beat tile
    tile_s1();
    // single-beat tile with extreme signed values
    run_cycle(1'b1, {8'h00, 8'h7F, 8'h80, 8'hFF}, 1'b1);
    idle(6);
    // bubble inside a four-beat tile
    run_cycle(1'b1, {8'd14, 8'd13, 8'd12, 8'd11}, 1'b0);
    run_cycle(1'b1, {8'd24, 8'd23, 8'd22, 8'd21}, 1'b0);
    run_cycle(1'b0, {8'hAA, 8'hAA, 8'hAA, 8'hAA}, 1'b1);
    run_cycle(1'b1, {8'd34, 8'd33, 8'd32, 8'd31}, 1'b0);
    run_cycle(1'b1, {8'd44, 8'd43, 8'd42, 8'd41}, 1'b1);
    idle(6);
    // valid held through DRAIN with changing data, next tile follows immediately
    run_cycle(1'b1, 32'h01020304, 1'b0);
    run_cycle(1'b1, 32'h05060708, 1'b1);
    for (int i = 0; i < ROWS + 3; i++)
      run_cycle(1'b1, $urandom, (i == ROWS + 2));
    idle(6);
    // reset in the middle of a stream, then a clean tile
    run_cycle(1'b1, 32'h11223344, 1'b0);
    run_cycle(1'b1, 32'h55667788, 1'b0);
    mid_reset();
    tile_s1();
    // randomised traffic
    for (int i = 0; i < 700; i++)
      run_cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 4) == 0));
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
